serial_tx_32: RTL and testbench

SERIAL_TX_32 -- requirements
Module: serial_tx_32

---
 rtl/serial_tx_32_pkg.sv | 20 ++
 rtl/mux_32x1.sv | 10 +
 rtl/serial_tx_32.sv | 97 +++++++++
 tb/tb_serial_tx_32.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_32_pkg.sv
// Shared definitions for the 32-bit parallel-to-serial transmitter:
// word/index widths, FSM state type and the index stepping helper.
package serial_tx_32_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit order decides the walking direction; wraparound is never reached
    // because the last index always ends or reloads the word.
    function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                  input logic             msb_first);
        return msb_first ? (idx - 5'd1) : (idx + 5'd1);
    endfunction

endpackage

// File: rtl/mux_32x1.sv
// Plain 32:1 bit selector used to pick the current serial bit out of the held word.
module mux_32x1 (
    input  logic [31:0] a,
    input  logic [4:0]  sel,
    output logic        y
);

    assign y = a[sel];

endmodule

// File: rtl/serial_tx_32.sv
// Serializes 32-bit words onto a valid/ready bit stream, LSB- or MSB-first,
// with zero-bubble back-to-back words, synchronous flush and async reset.
module serial_tx_32
    import serial_tx_32_pkg::*;
#(
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_first,
    output logic        ser_last,
    output logic        busy
);

    localparam logic [IDX_W-1:0] START_IDX = MSB_FIRST ? 5'd31 : 5'd0;
    localparam logic [IDX_W-1:0] END_IDX   = MSB_FIRST ? 5'd0  : 5'd31;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                mux_bit;
    logic                beat;
    logic                accept_ok;
    logic                capture;

    mux_32x1 u_mux (
        .a   (data_q),
        .sel (idx_q),
        .y   (mux_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= START_IDX;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // accept_ok ignores rst on purpose: the flops are held in reset anyway,
    // and rst only has to mask the visible in_ready.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        ser_valid = (state_q == SHIFT);
        busy      = (state_q == SHIFT);
        ser_first = ser_valid && (idx_q == START_IDX);
        ser_last  = ser_valid && (idx_q == END_IDX);
        ser_bit   = ser_valid ? mux_bit : IDLE_LEVEL;
        beat      = ser_valid && ser_ready;
        accept_ok = 1'b0;

        if (!flush) begin
            if (state_q == IDLE) begin
                accept_ok = 1'b1;
            end else begin
                accept_ok = ser_last && ser_ready;
            end
        end

        in_ready = accept_ok && !rst;
        capture  = in_valid && accept_ok;

        // Flush outranks everything; a capture in SHIFT is always also the
        // final beat, so it simply reloads instead of advancing.
        if (flush) begin
            state_d = IDLE;
            idx_d   = START_IDX;
            data_d  = '0;
        end else if (capture) begin
            state_d = SHIFT;
            idx_d   = START_IDX;
            data_d  = in_data;
        end else if (beat) begin
            if (ser_last) begin
                state_d = IDLE;
                idx_d   = START_IDX;
            end else begin
                idx_d = idx_step(idx_q, MSB_FIRST);
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_32.sv
// Bench for serial_tx_32: an LSB-first and an MSB-first instance share stimulus
// and are checked every cycle against a word/beat-count model plus directed scenarios.
module tb_serial_tx_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        ser_ready = 1'b0;

    logic lsb_in_ready, lsb_ser_bit, lsb_ser_valid, lsb_ser_first, lsb_ser_last, lsb_busy;
    logic msb_in_ready, msb_ser_bit, msb_ser_valid, msb_ser_first, msb_ser_last, msb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx_32 #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(lsb_in_ready), .flush(flush), .ser_bit(lsb_ser_bit),
        .ser_valid(lsb_ser_valid), .ser_ready(ser_ready), .ser_first(lsb_ser_first),
        .ser_last(lsb_ser_last), .busy(lsb_busy)
    );

    serial_tx_32 #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(msb_in_ready), .flush(flush), .ser_bit(msb_ser_bit),
        .ser_valid(msb_ser_valid), .ser_ready(ser_ready), .ser_first(msb_ser_first),
        .ser_last(msb_ser_last), .busy(msb_busy)
    );

    // Model: a word is in flight with m_cnt beats already delivered.
    logic        m_busy = 1'b0;
    logic [31:0] m_word = '0;
    logic [4:0]  m_cnt  = '0;
    logic        m_ready;

    always_comb m_ready = !rst && !flush && (!m_busy || (m_cnt == 5'd31 && ser_ready));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (in_valid && m_ready) begin
            m_busy <= 1'b1;
            m_word <= in_data;
            m_cnt  <= '0;
        end else if (m_busy && ser_ready) begin
            if (m_cnt == 5'd31) m_busy <= 1'b0;
            m_cnt <= m_cnt + 5'd1;
        end
    end

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkInt(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic checkOutput();
        logic e_first, e_last;
        e_first = m_busy && (m_cnt == 5'd0);
        e_last  = m_busy && (m_cnt == 5'd31);
        chk1("lsb_valid", lsb_ser_valid, m_busy);
        chk1("lsb_busy",  lsb_busy,      m_busy);
        chk1("lsb_bit",   lsb_ser_bit,   m_busy ? m_word[m_cnt] : 1'b0);
        chk1("lsb_first", lsb_ser_first, e_first);
        chk1("lsb_last",  lsb_ser_last,  e_last);
        chk1("lsb_ready", lsb_in_ready,  m_ready);
        chk1("msb_valid", msb_ser_valid, m_busy);
        chk1("msb_busy",  msb_busy,      m_busy);
        chk1("msb_bit",   msb_ser_bit,   m_busy ? m_word[5'd31 - m_cnt] : 1'b1);
        chk1("msb_first", msb_ser_first, e_first);
        chk1("msb_last",  msb_ser_last,  e_last);
        chk1("msb_ready", msb_in_ready,  m_ready);
    endtask

    always @(negedge clk) begin
        #2;
        checkOutput();
    end

    // Per-scenario recording of what the LSB/MSB instances emit on beats.
    logic [63:0] stream_lsb, stream_msb;
    int rec_beats, rec_cycle, first_valid_cyc, last_beat_cyc;
    int first_cnt, first_pos, last_cnt, last_pos, msb_first_pos, msb_last_pos;
    int ready_pulses, ready_bad;

    task automatic resetRec();
        stream_lsb = '0; stream_msb = '0;
        rec_beats = 0; rec_cycle = 0; first_valid_cyc = -1; last_beat_cyc = -1;
        first_cnt = 0; first_pos = -1; last_cnt = 0; last_pos = -1;
        msb_first_pos = -1; msb_last_pos = -1;
        ready_pulses = 0; ready_bad = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic f,
                                 input logic r, input logic rs);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        ser_ready = r;
        rst       = rs;
        #1;
    endtask

    task automatic stepRec(input logic v, input logic [31:0] d, input logic f, input logic r);
        applyStimulus(v, d, f, r, 1'b0);
        if (lsb_ser_valid && first_valid_cyc < 0) first_valid_cyc = rec_cycle;
        if (lsb_ser_valid && r && rec_beats < 64) begin
            stream_lsb[rec_beats[5:0]] = lsb_ser_bit;
            stream_msb[rec_beats[5:0]] = msb_ser_bit;
            if (lsb_ser_first) begin first_cnt++; first_pos = rec_beats; end
            if (lsb_ser_last)  begin last_cnt++;  last_pos  = rec_beats; end
            if (msb_ser_first) msb_first_pos = rec_beats;
            if (msb_ser_last)  msb_last_pos  = rec_beats;
            if (lsb_in_ready) begin
                ready_pulses++;
                if ((rec_beats % 32) != 31) ready_bad++;
            end
            last_beat_cyc = rec_cycle;
            rec_beats++;
        end
        rec_cycle++;
    endtask

    initial begin
        logic [31:0] w;

        // Reset state, then release
        #1;
        chk1("rst_valid", lsb_ser_valid, 1'b0);
        chk1("rst_ready", lsb_in_ready, 1'b0);
        chk1("rst_msb_bit", msb_ser_bit, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk1("post_rst_ready", lsb_in_ready, 1'b1);
        chk1("post_rst_busy", lsb_busy, 1'b0);

        // LSB/MSB order of one word
        resetRec();
        applyStimulus(1'b1, 32'hA5A5_0F01, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 36; k++) stepRec(1'b0, '0, 1'b0, 1'b1);
        chkInt("w1_beats", rec_beats, 32);
        chk32("w1_lsb_stream", stream_lsb[31:0], 32'hA5A5_0F01);
        chk32("w1_msb_stream", stream_msb[31:0], 32'h80F0_A5A5);
        chkInt("w1_first_pos", first_pos, 0);
        chkInt("w1_first_cnt", first_cnt, 1);
        chkInt("w1_last_pos", last_pos, 31);
        chkInt("w1_last_cnt", last_cnt, 1);
        chk1("w1_idle_after", lsb_busy, 1'b0);

        resetRec();
        applyStimulus(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 36; k++) stepRec(1'b0, '0, 1'b0, 1'b1);
        chk32("w2_msb_stream", stream_msb[31:0], 32'h8000_0001);
        chkInt("w2_msb_first_pos", msb_first_pos, 0);
        chkInt("w2_msb_last_pos", msb_last_pos, 31);

        // Back-to-back words, in_valid held throughout the first word
        resetRec();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) stepRec(1'b1, 32'h0000_0000, 1'b0, 1'b1);
        for (int k = 0; k < 36; k++) stepRec(1'b0, 32'h1234_5678, 1'b0, 1'b1);
        chkInt("b2b_beats", rec_beats, 64);
        chk32("b2b_word0", stream_lsb[31:0], 32'hFFFF_FFFF);
        chk32("b2b_word1", stream_lsb[63:32], 32'h0000_0000);
        chkInt("b2b_span", last_beat_cyc - first_valid_cyc, 63);
        chkInt("b2b_ready_pulses", ready_pulses, 2);
        chkInt("b2b_ready_bad", ready_bad, 0);

        // Stall pattern 1,0,0,1
        resetRec();
        w = $urandom;
        applyStimulus(1'b1, w, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 100 && rec_beats < 32; k++)
            stepRec(1'b0, '0, 1'b0, ((k % 4) == 0) || ((k % 4) == 3));
        chkInt("stall_beats", rec_beats, 32);
        chk32("stall_stream", stream_lsb[31:0], w);
        chkInt("stall_cycles", last_beat_cyc - first_valid_cyc + 1, 64);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Flush at beat 10, then restart
        resetRec();
        applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) stepRec(1'b1, $urandom, 1'b0, 1'b1);
        applyStimulus(1'b1, '1, 1'b1, 1'b1, 1'b0);
        chk1("flush_ready_low", lsb_in_ready, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk1("flush_valid_low", lsb_ser_valid, 1'b0);
        w = $urandom;
        applyStimulus(1'b1, w, 1'b0, 1'b1, 1'b0);
        chk1("flush_ready_back", lsb_in_ready, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("restart_first", lsb_ser_first, 1'b1);
        chk1("restart_lsb_bit", lsb_ser_bit, w[0]);
        chk1("restart_msb_bit", msb_ser_bit, w[31]);
        for (int k = 0; k < 34; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Flush in IDLE only blocks that cycle's capture
        applyStimulus(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        chk1("idle_flush_ready", lsb_in_ready, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk1("idle_flush_nocap", lsb_busy, 1'b0);

        // Asynchronous reset mid-word
        applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk1("arst_valid", lsb_ser_valid, 1'b0);
        chk1("arst_busy", lsb_busy, 1'b0);
        chk1("arst_msb_busy", msb_busy, 1'b0);
        chk1("arst_lsb_bit", lsb_ser_bit, 1'b0);
        chk1("arst_msb_bit", msb_ser_bit, 1'b1);
        chk1("arst_ready", lsb_in_ready, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        resetRec();
        for (int k = 0; k < 10; k++) stepRec(1'b0, '0, 1'b0, 1'b1);
        chkInt("arst_no_residual", first_valid_cyc, -1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 399) == 0));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
